// File: rtl/branch_resolver_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : branch_resolver_pkg
//  Brief   : Shared defaults and types for the branch resolver slice.
//  Revision: 1.0  initial release
// ============================================================================
package branch_resolver_pkg;

  localparam int WORD_SIZE_DEF    = 16;
  localparam int BTB_IDX_SIZE_DEF = 8;
  localparam int STAT_WIDTH_DEF   = 16;

  // Which stage currently owns the single BHT update port.
  typedef enum logic [1:0] {
    BHT_SRC_NONE  = 2'd0,
    BHT_SRC_EX    = 2'd1,
    BHT_SRC_DEFER = 2'd2,
    BHT_SRC_ID    = 2'd3
  } bht_src_e;

endpackage : branch_resolver_pkg
`default_nettype wire

// File: rtl/branch_stat_counter.sv
`default_nettype none
// ============================================================================
//  Module  : branch_stat_counter
//  Brief   : Saturating event counter; sticks at all-ones instead of wrapping.
//  Revision: 1.0  initial release
// ============================================================================
module branch_stat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;

  // Count one per strobe until every bit is set, then hold.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (inc && (r_count != {WIDTH{1'b1}})) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign count = r_count;

endmodule : branch_stat_counter
`default_nettype wire

// File: rtl/branch_resolver.sv
`default_nettype none
// ============================================================================
//  Module  : branch_resolver
//  Brief   : Tracks fetched PC / predicted next PC through IF/ID and ID/EX,
//            resolves jumps at ID and branches at EX, feeds BTB/BHT updates
//            back to the predictor and raises redirect/flush on mispredict.
//  Revision: 1.0  initial release
// ============================================================================
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int WORD_SIZE    = WORD_SIZE_DEF,
  parameter int BTB_IDX_SIZE = BTB_IDX_SIZE_DEF,
  parameter int STAT_WIDTH   = STAT_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  if_valid,
  input  logic [WORD_SIZE-1:0]  if_pc,
  input  logic [WORD_SIZE-1:0]  if_predicted_pc,
  input  logic                  id_stall,
  input  logic                  id_is_jump,
  input  logic                  id_is_branch,
  input  logic [WORD_SIZE-1:0]  id_target,
  input  logic                  ex_branch_taken,
  output logic                  update_tag,
  output logic [WORD_SIZE-1:0]  pc_for_btb_update,
  output logic [WORD_SIZE-1:0]  branch_target_for_btb_update,
  output logic                  update_bht,
  output logic [WORD_SIZE-1:0]  pc_for_bht_update,
  output logic                  branch_correct_or_notCorrect,
  output logic                  redirect_valid,
  output logic [WORD_SIZE-1:0]  redirect_pc,
  output logic                  flush_if,
  output logic                  flush_id,
  output logic [STAT_WIDTH-1:0] resolve_count,
  output logic [STAT_WIDTH-1:0] mispredict_count
);

  // The predictor index is sliced out of the PC by the predictor itself;
  // here it only has to fit inside a PC.
  if (BTB_IDX_SIZE > WORD_SIZE) begin : g_idx_check
    $error("branch_resolver: BTB_IDX_SIZE exceeds WORD_SIZE");
  end

  // IF/ID slot
  logic                 r_ifid_v;
  logic [WORD_SIZE-1:0] r_ifid_pc;
  logic [WORD_SIZE-1:0] r_ifid_pred;

  // ID/EX slot
  logic                 r_idex_v;
  logic [WORD_SIZE-1:0] r_idex_pc;
  logic [WORD_SIZE-1:0] r_idex_pred;
  logic                 r_idex_is_br;
  logic [WORD_SIZE-1:0] r_idex_target;
  logic                 r_idex_bht_pend;
  logic                 r_idex_correct;

  // Resolution terms
  logic                 w_ex_resolve;
  logic [WORD_SIZE-1:0] w_ex_actual;
  logic                 w_ex_correct;
  logic                 w_ex_mispredict;
  logic                 w_deferred;
  logic                 w_ex_port_busy;
  logic                 w_id_live;
  logic                 w_id_jump;
  logic                 w_id_branch;
  logic                 w_id_correct;
  logic                 w_id_mispredict;
  logic                 w_defer_now;
  bht_src_e             w_bht_src;

  assign w_ex_resolve    = r_idex_v && r_idex_is_br;
  assign w_ex_actual     = ex_branch_taken ? r_idex_target : (r_idex_pc + WORD_SIZE'(1));
  assign w_ex_correct    = (r_idex_pred == w_ex_actual);
  assign w_ex_mispredict = w_ex_resolve && !w_ex_correct;
  // A deferred jump never coexists with a branch in EX (slot holds one instr).
  assign w_deferred      = r_idex_v && r_idex_bht_pend;
  assign w_ex_port_busy  = w_ex_resolve || w_deferred;

  // ID only resolves a real, non-stalled, right-path instruction.
  assign w_id_live       = r_ifid_v && !id_stall && !w_ex_mispredict;
  assign w_id_jump       = w_id_live && id_is_jump;
  assign w_id_branch     = w_id_live && id_is_branch;
  assign w_id_correct    = (r_ifid_pred == id_target);
  assign w_id_mispredict = w_id_jump && !w_id_correct;
  assign w_defer_now     = w_id_jump && w_ex_port_busy;

  // Pick the owner of the BHT port: EX branch, then deferred jump, then ID jump.
  always_comb begin
    w_bht_src = BHT_SRC_NONE;
    if (w_ex_resolve) begin
      w_bht_src = BHT_SRC_EX;
    end else if (w_deferred) begin
      w_bht_src = BHT_SRC_DEFER;
    end else if (w_id_jump) begin
      w_bht_src = BHT_SRC_ID;
    end
  end

  // Predictor update, redirect and flush outputs; silent while in reset.
  always_comb begin
    update_tag                   = 1'b0;
    pc_for_btb_update            = '0;
    branch_target_for_btb_update = '0;
    update_bht                   = 1'b0;
    pc_for_bht_update            = '0;
    branch_correct_or_notCorrect = 1'b0;
    redirect_valid               = 1'b0;
    redirect_pc                  = '0;
    flush_if                     = 1'b0;
    flush_id                     = 1'b0;
    if (reset_n) begin
      if (w_id_jump || w_id_branch) begin
        update_tag                   = 1'b1;
        pc_for_btb_update            = r_ifid_pc;
        branch_target_for_btb_update = id_target;
      end
      case (w_bht_src)
        BHT_SRC_EX: begin
          update_bht                   = 1'b1;
          pc_for_bht_update            = r_idex_pc;
          branch_correct_or_notCorrect = w_ex_correct;
        end
        BHT_SRC_DEFER: begin
          update_bht                   = 1'b1;
          pc_for_bht_update            = r_idex_pc;
          branch_correct_or_notCorrect = r_idex_correct;
        end
        BHT_SRC_ID: begin
          update_bht                   = 1'b1;
          pc_for_bht_update            = r_ifid_pc;
          branch_correct_or_notCorrect = w_id_correct;
        end
        default: begin
        end
      endcase
      if (w_ex_mispredict) begin
        redirect_valid = 1'b1;
        redirect_pc    = w_ex_actual;
        flush_if       = 1'b1;
        flush_id       = 1'b1;
      end else if (w_id_mispredict) begin
        redirect_valid = 1'b1;
        redirect_pc    = id_target;
        flush_if       = 1'b1;
      end
    end
  end

  // IF/ID slot: flush kills, stall holds, otherwise capture the fetch.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ifid_v    <= 1'b0;
      r_ifid_pc   <= '0;
      r_ifid_pred <= '0;
    end else if (flush_if) begin
      r_ifid_v <= 1'b0;
    end else if (!id_stall) begin
      r_ifid_v    <= if_valid;
      r_ifid_pc   <= if_pc;
      r_ifid_pred <= if_predicted_pc;
    end
  end

  // ID/EX slot: bubble on flush or stall, otherwise advance the ID instruction.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_idex_v        <= 1'b0;
      r_idex_pc       <= '0;
      r_idex_pred     <= '0;
      r_idex_is_br    <= 1'b0;
      r_idex_target   <= '0;
      r_idex_bht_pend <= 1'b0;
      r_idex_correct  <= 1'b0;
    end else if (flush_id || id_stall) begin
      r_idex_v        <= 1'b0;
      r_idex_bht_pend <= 1'b0;
    end else begin
      r_idex_v        <= r_ifid_v;
      r_idex_pc       <= r_ifid_pc;
      r_idex_pred     <= r_ifid_pred;
      r_idex_is_br    <= w_id_branch;
      r_idex_target   <= id_target;
      r_idex_bht_pend <= w_defer_now;
      r_idex_correct  <= w_id_correct;
    end
  end

  branch_stat_counter #(
    .WIDTH (STAT_WIDTH)
  ) u_resolve_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (update_bht),
    .count   (resolve_count)
  );

  branch_stat_counter #(
    .WIDTH (STAT_WIDTH)
  ) u_mispredict_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (update_bht && !branch_correct_or_notCorrect),
    .count   (mispredict_count)
  );

endmodule : branch_resolver
`default_nettype wire

// File: tb/tb_branch_resolver.sv
`default_nettype none
// ============================================================================
//  Module  : tb_branch_resolver
//  Brief   : Directed self-checking bench for branch_resolver.
//  Revision: 1.0  initial release
// ============================================================================
module tb_branch_resolver;

  localparam int W = 16;
  localparam int S = 3;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         if_valid;
  logic [W-1:0] if_pc;
  logic [W-1:0] if_predicted_pc;
  logic         id_stall;
  logic         id_is_jump;
  logic         id_is_branch;
  logic [W-1:0] id_target;
  logic         ex_branch_taken;
  logic         update_tag;
  logic [W-1:0] pc_for_btb_update;
  logic [W-1:0] branch_target_for_btb_update;
  logic         update_bht;
  logic [W-1:0] pc_for_bht_update;
  logic         branch_correct_or_notCorrect;
  logic         redirect_valid;
  logic [W-1:0] redirect_pc;
  logic         flush_if;
  logic         flush_id;
  logic [S-1:0] resolve_count;
  logic [S-1:0] mispredict_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_resolver #(
    .WORD_SIZE    (W),
    .BTB_IDX_SIZE (8),
    .STAT_WIDTH   (S)
  ) dut (
    .clk                          (clk),
    .reset_n                      (reset_n),
    .if_valid                     (if_valid),
    .if_pc                        (if_pc),
    .if_predicted_pc              (if_predicted_pc),
    .id_stall                     (id_stall),
    .id_is_jump                   (id_is_jump),
    .id_is_branch                 (id_is_branch),
    .id_target                    (id_target),
    .ex_branch_taken              (ex_branch_taken),
    .update_tag                   (update_tag),
    .pc_for_btb_update            (pc_for_btb_update),
    .branch_target_for_btb_update (branch_target_for_btb_update),
    .update_bht                   (update_bht),
    .pc_for_bht_update            (pc_for_bht_update),
    .branch_correct_or_notCorrect (branch_correct_or_notCorrect),
    .redirect_valid               (redirect_valid),
    .redirect_pc                  (redirect_pc),
    .flush_if                     (flush_if),
    .flush_id                     (flush_id),
    .resolve_count                (resolve_count),
    .mispredict_count             (mispredict_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle();
    if_valid        = 1'b0;
    if_pc           = '0;
    if_predicted_pc = '0;
    id_stall        = 1'b0;
    id_is_jump      = 1'b0;
    id_is_branch    = 1'b0;
    id_target       = '0;
    ex_branch_taken = 1'b0;
  endtask

  task automatic fetch(input logic [W-1:0] pc, input logic [W-1:0] pred);
    if_valid        = 1'b1;
    if_pc           = pc;
    if_predicted_pc = pred;
  endtask

  task automatic chk_bht(input string tag, input logic v, input logic [W-1:0] pc, input logic c);
    chk({tag, ".update_bht"}, update_bht, v);
    if (v) begin
      chk({tag, ".pc_bht"}, pc_for_bht_update, pc);
      chk({tag, ".correct"}, branch_correct_or_notCorrect, c);
    end
  endtask

  task automatic chk_tag(input string tag, input logic v, input logic [W-1:0] pc, input logic [W-1:0] tgt);
    chk({tag, ".update_tag"}, update_tag, v);
    if (v) begin
      chk({tag, ".pc_btb"}, pc_for_btb_update, pc);
      chk({tag, ".tgt_btb"}, branch_target_for_btb_update, tgt);
    end
  endtask

  task automatic chk_redir(input string tag, input logic v, input logic [W-1:0] pc, input logic fi, input logic fd);
    chk({tag, ".redirect_valid"}, redirect_valid, v);
    if (v) chk({tag, ".redirect_pc"}, redirect_pc, pc);
    chk({tag, ".flush_if"}, flush_if, fi);
    chk({tag, ".flush_id"}, flush_id, fd);
  endtask

  task automatic chk_cnt(input string tag, input int r, input int m);
    chk({tag, ".resolve_count"}, resolve_count, r);
    chk({tag, ".mispredict_count"}, mispredict_count, m);
  endtask

  task automatic chk_quiet(input string tag);
    chk_tag(tag, 1'b0, '0, '0);
    chk_bht(tag, 1'b0, '0, 1'b0);
    chk_redir(tag, 1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    idle();
    reset_n = 1'b0;
    tick();
    tick();

    // Reset state
    mid();
    chk_quiet("reset");
    chk_cnt("reset", 0, 0);
    reset_n = 1'b1;
    tick();

    // JMP mispredicted at ID
    fetch(16'h0010, 16'h0011);
    tick();
    idle();
    id_is_jump = 1'b1;
    id_target  = 16'h0040;
    mid();
    chk_tag("jmp_id", 1'b1, 16'h0010, 16'h0040);
    chk_bht("jmp_id", 1'b1, 16'h0010, 1'b0);
    chk_redir("jmp_id", 1'b1, 16'h0040, 1'b1, 1'b0);
    tick();
    idle();
    mid();
    chk_quiet("jmp_after");
    chk_cnt("jmp_after", 1, 1);

    // BEQ taken, predicted fall-through: resolves wrong at EX
    fetch(16'h0020, 16'h0021);
    tick();
    fetch(16'h0021, 16'h0022);
    id_is_branch = 1'b1;
    id_target    = 16'h0030;
    mid();
    chk_tag("beq_t_id", 1'b1, 16'h0020, 16'h0030);
    chk_bht("beq_t_id", 1'b0, '0, 1'b0);
    chk_redir("beq_t_id", 1'b0, '0, 1'b0, 1'b0);
    tick();
    idle();
    ex_branch_taken = 1'b1;
    id_is_jump      = 1'b1;   // wrong-path jump sitting in ID
    id_target       = 16'h0099;
    mid();
    chk_tag("beq_t_ex", 1'b0, '0, '0);
    chk_bht("beq_t_ex", 1'b1, 16'h0020, 1'b0);
    chk_redir("beq_t_ex", 1'b1, 16'h0030, 1'b1, 1'b1);
    tick();
    idle();
    id_is_jump = 1'b1;
    id_target  = 16'h0099;
    mid();
    chk_quiet("beq_t_after");
    chk_cnt("beq_t_after", 2, 2);
    tick();
    idle();

    // Same BEQ not taken: correct at EX
    fetch(16'h0020, 16'h0021);
    tick();
    idle();
    id_is_branch = 1'b1;
    id_target    = 16'h0030;
    mid();
    chk_tag("beq_n_id", 1'b1, 16'h0020, 16'h0030);
    tick();
    idle();
    mid();
    chk_tag("beq_n_ex", 1'b0, '0, '0);
    chk_bht("beq_n_ex", 1'b1, 16'h0020, 1'b1);
    chk_redir("beq_n_ex", 1'b0, '0, 1'b0, 1'b0);
    tick();
    mid();
    chk_cnt("beq_n_after", 3, 2);

    // Correct BEQ in EX while a correctly predicted JMP sits in ID
    fetch(16'h0050, 16'h0051);
    tick();
    fetch(16'h0051, 16'h0070);
    id_is_branch = 1'b1;
    id_target    = 16'h0060;
    tick();
    idle();
    id_is_jump = 1'b1;
    id_target  = 16'h0070;
    mid();
    chk_bht("dual_ex", 1'b1, 16'h0050, 1'b1);
    chk_tag("dual_ex", 1'b1, 16'h0051, 16'h0070);
    chk_redir("dual_ex", 1'b0, '0, 1'b0, 1'b0);
    tick();
    idle();
    mid();
    chk_tag("dual_defer", 1'b0, '0, '0);
    chk_bht("dual_defer", 1'b1, 16'h0051, 1'b1);
    chk_redir("dual_defer", 1'b0, '0, 1'b0, 1'b0);
    tick();
    mid();
    chk_quiet("dual_after");
    chk_cnt("dual_after", 5, 2);

    // JMP held by id_stall for 3 cycles, then resolves once
    fetch(16'h0080, 16'h0081);
    tick();
    fetch(16'h0081, 16'h0082);
    id_stall   = 1'b1;
    id_is_jump = 1'b1;
    id_target  = 16'h0090;
    for (int i = 0; i < 3; i++) begin
      mid();
      chk_quiet($sformatf("stall_%0d", i));
      tick();
    end
    idle();
    id_is_jump = 1'b1;
    id_target  = 16'h0090;
    mid();
    chk_tag("stall_rel", 1'b1, 16'h0080, 16'h0090);
    chk_bht("stall_rel", 1'b1, 16'h0080, 1'b0);
    chk_redir("stall_rel", 1'b1, 16'h0090, 1'b1, 1'b0);
    tick();
    idle();
    mid();
    chk_quiet("stall_after");
    chk_cnt("stall_after", 6, 3);

    // EX mispredict while ID is stalled clears both slots
    fetch(16'h00A0, 16'h00A1);
    tick();
    fetch(16'h00A1, 16'h00A2);
    id_is_branch = 1'b1;
    id_target    = 16'h00B0;
    tick();
    idle();
    id_stall        = 1'b1;
    ex_branch_taken = 1'b1;
    id_is_jump      = 1'b1;
    id_target       = 16'h00C0;
    mid();
    chk_tag("flush_stall", 1'b0, '0, '0);
    chk_bht("flush_stall", 1'b1, 16'h00A0, 1'b0);
    chk_redir("flush_stall", 1'b1, 16'h00B0, 1'b1, 1'b1);
    tick();
    idle();
    id_is_jump = 1'b1;
    id_target  = 16'h00C0;
    mid();
    chk_quiet("flush_stall_after");
    chk_cnt("flush_stall_after", 7, 4);
    tick();
    idle();

    // One more correct branch: resolve_count saturates at all-ones
    fetch(16'h00E0, 16'h00E1);
    tick();
    idle();
    id_is_branch = 1'b1;
    id_target    = 16'h00F0;
    tick();
    idle();
    mid();
    chk_bht("sat_ex", 1'b1, 16'h00E0, 1'b1);
    tick();
    mid();
    chk_cnt("sat_after", 7, 4);

    // Reset mid-flight with a mispredicting branch in EX
    fetch(16'h00D0, 16'h00D1);
    tick();
    fetch(16'h00D1, 16'h00D2);
    id_is_branch = 1'b1;
    id_target    = 16'h00DD;
    tick();
    idle();
    ex_branch_taken = 1'b1;
    id_is_jump      = 1'b1;
    id_target       = 16'h0077;
    reset_n         = 1'b0;
    mid();
    chk_quiet("rst_mid");
    tick();
    reset_n         = 1'b1;
    ex_branch_taken = 1'b1;
    id_is_jump      = 1'b1;
    mid();
    chk_quiet("rst_after");
    chk_cnt("rst_after", 0, 0);
    tick();
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_branch_resolver
`default_nettype wire
